fwd_stall_ctrl: RTL and testbench
=================================

Name: fwd_stall_ctrl

Overview:
Parametrised forwarding and hazard controller for the interrupt-capable 5-stage pipelined CPU. It generalises operand forwarding to NSRC source ports and adds load-use stall detection. It also adds a multi-cycle unit (MDU, mul/div) scoreboard FSM covering RAW and structural hazards, and a saturating stall-cycle counter. The block sits beside the ID stage and drives the operand bypass muxes and the PC/IF-ID freeze.

Parameters:
RA_W, 5, register address width; register 0 is hardwired zero.
NSRC, 2, number of ID source operands (rs, rt, optionally more).
MDU_LAT, 4, MDU cycles from issue to write-back; legal range 1..15.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
id_src  in  NSRC*RA_W  ID source register numbers; source i at bits [i*RA_W +: RA_W]
id_use  in  NSRC  bit i=1: source i is actually read
id_valid  in  1  ID holds a real instruction
id_is_mdu  in  1  ID instruction issues an MDU op
id_mdu_rd  in  RA_W  MDU destination register
exe_rn, mem_rn  in  RA_W  destination registers in EXE and MEM
exe_wreg, mem_wreg  in  1  stage writes a register
exe_m2reg, mem_m2reg  in  1  stage is a load
flush  in  1  interrupt/exception flush of IF/ID/EXE this cycle
fwd_sel  out  NSRC*2  per source: 00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load data
stall  out  1  freeze PC and IF/ID, inject bubble into EXE
mdu_busy  out  1  MDU FSM in BUSY
mdu_done  out  1  one-cycle pulse: MDU result written this cycle
mdu_rd  out  RA_W  register being produced by MDU (0 when idle)
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst=1): FSM=IDLE, down-counter=0, mdu_rd=0, mdu_busy=0, mdu_done=0, stall_cnt=0. fwd_sel and stall are combinational; they are 0 whenever inputs are quiescent.
- fwd_sel per source i (combinational, zero latency). A match requires id_use[i], stage wreg=1, rn!=0 and rn==src_i. Priority order:
  - EXE match with exe_m2reg=0 -> 01.
  - Otherwise MEM match with mem_m2reg=0 -> 10.
  - Otherwise MEM match with mem_m2reg=1 -> 11.
  - Otherwise 00.
  - An EXE load match never selects MEM; it produces a stall instead, and fwd_sel is then don't-care.
- Hazard terms (combinational), all gated by id_valid:
  - load_use: any used source matches EXE with exe_m2reg=1.
  - mdu_raw: FSM=BUSY, mdu_rd!=0, and any used source == mdu_rd.
  - mdu_struct: FSM=BUSY and id_is_mdu.
- stall = (load_use | mdu_raw | mdu_struct) & ~flush. Flush always wins: stall=0 in a flush cycle.
- MDU FSM, states IDLE/BUSY:
  - IDLE -> BUSY when id_valid & id_is_mdu & ~stall & ~flush. On this edge: capture mdu_rd=id_mdu_rd, load counter=MDU_LAT-1.
  - BUSY: counter decrements each cycle. While counter==0, mdu_done=1; the next edge goes to IDLE with mdu_rd=0.
  - mdu_busy=1 for exactly MDU_LAT cycles, including the done cycle.
  - The hazard terms remain active in the done cycle. A dependent instruction issues the cycle after mdu_done.
  - Back-to-back MDU ops therefore have MDU_LAT+1 cycles between issues.
- flush does not abort an MDU op already in BUSY; the op is committed. flush in the issue cycle suppresses the issue.
- rst asserted mid-BUSY: immediate return to IDLE, no mdu_done pulse.
- stall_cnt increments on every edge where stall=1. It saturates at all-ones and never wraps.
- Source register 0 never causes a forward, a match or a stall.

Test Plan:
- No-hazard forward: src0=3, src1=3, exe_rn=3 exe_wreg=1 exe_m2reg=0, mem_rn=3 mem_wreg=1 -> fwd_sel={01,01}, stall=0 (EXE priority). With exe_wreg=0 and mem_m2reg=1 -> {11,11}.
- Load-use: exe_rn=5 exe_m2reg=1 exe_wreg=1, src1=5 id_use=2'b10 -> stall=1, stall_cnt 0->1. Same with id_use=2'b01 -> stall=0. Same with flush=1 -> stall=0, counter unchanged.
- MDU issue/RAW, MDU_LAT=4: issue with id_mdu_rd=8 at cycle t; next instruction reads r8.
  - Required: mdu_busy=1 for cycles t+1..t+4, mdu_done=1 only at t+4.
  - stall=1 for t+1..t+4, 0 at t+5; stall_cnt=4.
- Structural: second MDU op presented at t+1 -> stall=1 until t+4, issues at t+5, busy again t+6..t+9.
- Reset mid-op: assert rst at t+2 -> mdu_busy=0, mdu_rd=0, stall_cnt=0 immediately; no mdu_done at t+4.
- Zero register and saturation:
  - src=0 with all stages writing r0 as loads -> fwd_sel=00, stall=0.
  - CNT_W=4 with 20 stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/fwd_stall_ctrl.sv
// Operand-forwarding select, load-use / MDU hazard stall, and MDU scoreboard
// for the 5-stage pipeline. Sits beside ID; drives bypass muxes and PC/IF-ID freeze.
module fwd_stall_ctrl #(
  parameter int RA_W    = 5,
  parameter int NSRC    = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*RA_W-1:0] id_src,
  input  logic [NSRC-1:0]      id_use,
  input  logic                 id_valid,
  input  logic                 id_is_mdu,
  input  logic [RA_W-1:0]      id_mdu_rd,
  input  logic [RA_W-1:0]      exe_rn,
  input  logic [RA_W-1:0]      mem_rn,
  input  logic                 exe_wreg,
  input  logic                 mem_wreg,
  input  logic                 exe_m2reg,
  input  logic                 mem_m2reg,
  input  logic                 flush,
  output logic [NSRC*2-1:0]    fwd_sel,
  output logic                 stall,
  output logic                 mdu_busy,
  output logic                 mdu_done,
  output logic [RA_W-1:0]      mdu_rd,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic {IDLE, BUSY} mdu_st_e;

  mdu_st_e          state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic [NSRC-1:0]  lu_v, raw_v;
  logic             load_use, mdu_raw, mdu_struct;

  // Per-source bypass select and hazard match; r0 never matches anything.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [RA_W-1:0] src;
    logic            exe_hit, mem_hit;
    assign src     = id_src[gi*RA_W +: RA_W];
    assign exe_hit = id_use[gi] & exe_wreg & (|exe_rn) & (exe_rn == src);
    assign mem_hit = id_use[gi] & mem_wreg & (|mem_rn) & (mem_rn == src);
    assign lu_v[gi]  = exe_hit & exe_m2reg;
    assign raw_v[gi] = id_use[gi] & (src == rd_q);
    assign fwd_sel[gi*2 +: 2] = (exe_hit & ~exe_m2reg) ? 2'b01 :
                                mem_hit ? (mem_m2reg ? 2'b11 : 2'b10) : 2'b00;
  end

  assign load_use   = id_valid & (|lu_v);
  assign mdu_raw    = id_valid & (state_q == BUSY) & (|rd_q) & (|raw_v);
  assign mdu_struct = id_valid & (state_q == BUSY) & id_is_mdu;
  assign stall      = (load_use | mdu_raw | mdu_struct) & ~flush;

  assign mdu_busy  = (state_q == BUSY);
  assign mdu_done  = (state_q == BUSY) & (cnt_q == 4'd0);
  assign mdu_rd    = rd_q;
  assign stall_cnt = scnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: if (id_valid & id_is_mdu & ~stall & ~flush) begin
        state_d = BUSY;
        cnt_d   = 4'(MDU_LAT - 1);
        rd_d    = id_mdu_rd;
      end
      BUSY: begin
        // flush does not abort an op in flight; it always runs to completion
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign scnt_d = (stall & ~(&scnt_q)) ? scnt_q + 1'b1 : scnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      scnt_q  <= scnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Randomized + directed bench for fwd_stall_ctrl against a cycle-indexed reference model.
module tb_fwd_stall_ctrl;
  localparam int RA_W = 5, NSRC = 2, LAT = 4, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic                 clk = 0, rst;
  logic [NSRC*RA_W-1:0] id_src;
  logic [NSRC-1:0]      id_use;
  logic                 id_valid, id_is_mdu, flush;
  logic [RA_W-1:0]      id_mdu_rd, exe_rn, mem_rn;
  logic                 exe_wreg, mem_wreg, exe_m2reg, mem_m2reg;
  logic [NSRC*2-1:0]    fwd_sel;
  logic                 stall, mdu_busy, mdu_done;
  logic [RA_W-1:0]      mdu_rd;
  logic [CNT_W-1:0]     stall_cnt;

  fwd_stall_ctrl #(.RA_W(RA_W), .NSRC(NSRC), .MDU_LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_src(id_src), .id_use(id_use), .id_valid(id_valid),
    .id_is_mdu(id_is_mdu), .id_mdu_rd(id_mdu_rd), .exe_rn(exe_rn), .mem_rn(mem_rn),
    .exe_wreg(exe_wreg), .mem_wreg(mem_wreg), .exe_m2reg(exe_m2reg), .mem_m2reg(mem_m2reg),
    .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .mdu_rd(mdu_rd), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  // model: the MDU op issued at cycle issue_cyc is busy for cycles issue_cyc+1 .. issue_cyc+LAT
  int cyc = 0, issue_cyc = -1000, m_rd = 0, m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return (cyc > issue_cyc) && (cyc <= issue_cyc + LAT);
  endfunction

  task automatic quiet();
    id_src = '0; id_use = '0; id_valid = 0; id_is_mdu = 0; id_mdu_rd = '0; flush = 0;
    exe_rn = '0; mem_rn = '0; exe_wreg = 0; mem_wreg = 0; exe_m2reg = 0; mem_m2reg = 0;
  endtask

  // Called at posedge+1 with inputs applied; checks this cycle, advances to next posedge+1.
  task automatic tick();
    bit lu, raw, st, busy;
    int s, fw;
    bit used, eh, mh;
    #3;
    lu = 0; raw = 0; busy = m_busy();
    for (int i = 0; i < NSRC; i++) begin
      s    = int'(id_src[i*RA_W +: RA_W]);
      used = id_use[i] && (s != 0);
      eh   = used && exe_wreg && (int'(exe_rn) == s);
      mh   = used && mem_wreg && (int'(mem_rn) == s);
      if (eh && exe_m2reg) lu = 1;
      else begin
        fw = eh ? 1 : (mh ? (mem_m2reg ? 3 : 2) : 0);
        chk($sformatf("fwd%0d", i), 32'(fwd_sel[i*2 +: 2]), 32'(fw));
      end
      if (busy && m_rd != 0 && id_use[i] && s == m_rd) raw = 1;
    end
    st = id_valid && (lu || raw || (busy && id_is_mdu)) && !flush;
    chk("stall", 32'(stall), 32'(st));
    chk("busy", 32'(mdu_busy), 32'(busy));
    chk("done", 32'(mdu_done), 32'(cyc == issue_cyc + LAT));
    chk("mdu_rd", 32'(mdu_rd), busy ? 32'(m_rd) : 32'd0);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (st && m_cnt < CMAX) m_cnt++;
    if (!busy && id_valid && id_is_mdu && !st && !flush) begin
      issue_cyc = cyc;
      m_rd = int'(id_mdu_rd);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; #1;
    chk("rst_busy", 32'(mdu_busy), 0);
    chk("rst_done", 32'(mdu_done), 0);
    chk("rst_rd", 32'(mdu_rd), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    issue_cyc = -1000; m_rd = 0; m_cnt = 0;
    @(posedge clk); #1;
    rst = 0; cyc++;
  endtask

  initial begin
    quiet(); rst = 1;
    @(posedge clk); #1;
    do_reset();
    #1 chk("quiet_fwd", 32'(fwd_sel), 0);
    chk("quiet_stall", 32'(stall), 0);
    tick();

    // forwarding priority
    id_valid = 1; id_src = {5'd3, 5'd3}; id_use = 2'b11;
    exe_rn = 3; exe_wreg = 1; mem_rn = 3; mem_wreg = 1;
    #1 chk("fwd_exe_pri", 32'(fwd_sel), 32'b0101);
    tick();
    exe_wreg = 0; mem_m2reg = 1;
    #1 chk("fwd_mem_ld", 32'(fwd_sel), 32'b1111);
    tick();

    // load-use
    quiet(); id_valid = 1; exe_rn = 5; exe_wreg = 1; exe_m2reg = 1;
    id_src = {5'd5, 5'd0}; id_use = 2'b10;
    tick();
    chk("lu_cnt", 32'(stall_cnt), 1);
    id_use = 2'b01; tick();
    id_use = 2'b10; flush = 1; tick();
    chk("lu_flush_cnt", 32'(stall_cnt), 1);

    // zero register
    quiet(); id_valid = 1; id_use = 2'b11;
    exe_wreg = 1; exe_m2reg = 1; mem_wreg = 1; mem_m2reg = 1;
    #1 chk("r0_fwd", 32'(fwd_sel), 0);
    chk("r0_stall", 32'(stall), 0);
    tick();

    // MDU RAW
    quiet(); do_reset();
    id_valid = 1; id_is_mdu = 1; id_mdu_rd = 8; tick();
    id_is_mdu = 0; id_src = {5'd0, 5'd8}; id_use = 2'b01;
    repeat (4) tick();
    chk("raw_busy_end", 32'(mdu_busy), 0);
    chk("raw_cnt", 32'(stall_cnt), 4);
    tick();

    // MDU structural
    quiet(); do_reset();
    id_valid = 1; id_is_mdu = 1; id_mdu_rd = 8; tick();
    id_mdu_rd = 9;
    repeat (5) tick();
    quiet(); tick();
    chk("struct_busy2", 32'(mdu_busy), 1);
    chk("struct_rd2", 32'(mdu_rd), 9);
    repeat (4) tick();

    // reset mid-op
    quiet(); do_reset();
    id_valid = 1; id_is_mdu = 1; id_mdu_rd = 8; tick();
    quiet(); tick();
    do_reset();
    repeat (3) tick();

    // saturation
    quiet(); do_reset();
    id_valid = 1; exe_rn = 5; exe_wreg = 1; exe_m2reg = 1;
    id_src = {5'd5, 5'd0}; id_use = 2'b10;
    repeat (20) tick();
    chk("sat_cnt", 32'(stall_cnt), 15);

    // randomized
    quiet(); do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin quiet(); do_reset(); end
      id_src    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_use    = 2'($urandom);
      id_valid  = ($urandom_range(0, 9) != 0);
      id_is_mdu = ($urandom_range(0, 3) == 0);
      id_mdu_rd = 5'($urandom_range(0, 7));
      exe_rn    = 5'($urandom_range(0, 7));
      mem_rn    = 5'($urandom_range(0, 7));
      exe_wreg  = 1'($urandom); mem_wreg  = 1'($urandom);
      exe_m2reg = ($urandom_range(0, 3) == 0);
      mem_m2reg = 1'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
